// File: rtl/mac_pkg.sv
// mac_pkg: shared types, default sizing and helpers for the pipelined MAC.
//   DEF_*            default sizing of mac_pipe
//   K, PROD_W, TREE_W derived widths for the default sizing
//   clog2()          ceiling log2, usable in constant expressions
//   round_shift_sat() requantisation: round half up, arithmetic shift, saturate
package mac_pkg;

  localparam int unsigned DEF_DATA_SIZE     = 8;
  localparam int unsigned DEF_KERNEL_WIDTH  = 3;
  localparam int unsigned DEF_KERNEL_LENGTH = 3;
  localparam int unsigned DEF_ACC_SIZE      = 32;
  localparam int unsigned DEF_SHIFT_W       = 5;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned K      = DEF_KERNEL_WIDTH * DEF_KERNEL_LENGTH;
  localparam int unsigned PROD_W = 2 * DEF_DATA_SIZE;
  localparam int unsigned TREE_W = PROD_W + clog2(K);

  // Requantise an acc_w-bit signed total (sign-extended into 64 bits) down to
  // data_w bits. The 64-bit working width leaves headroom for the rounding
  // add, so acc_w must stay at or below 62.
  function automatic longint round_shift_sat(input longint      total,
                                             input int unsigned acc_w,
                                             input int unsigned shift,
                                             input int unsigned data_w);
    int unsigned s;
    longint      v;
    longint      hi;
    longint      lo;
    s = (shift > acc_w - 1) ? acc_w - 1 : shift;
    v = total;
    if (s > 0) begin
      v = v + (64'sd1 <<< (s - 1));
    end
    v  = v >>> s;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: combinational balanced signed reduction of N IN_W-bit terms.
//   terms  in   N*IN_W   packed signed terms, term i at [i*IN_W +: IN_W]
//   sum_c  out  OUT_W    signed sum (combinational)
// Leaves are padded with zeros up to the next power of two; node i sums
// nodes 2i+1 and 2i+2, so node 0 is the root.
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int unsigned N     = K,
  parameter int unsigned IN_W  = PROD_W,
  parameter int unsigned OUT_W = TREE_W
) (
  input  logic [N*IN_W-1:0]       terms,
  output logic signed [OUT_W-1:0] sum_c
);

  localparam int unsigned LVL   = clog2(N);
  localparam int unsigned LEAVES = 32'd1 << LVL;
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  logic signed [OUT_W-1:0] node [NODES];

  // Leaf load then bottom-up pairwise reduction.
  always_comb begin
    for (int i = 0; i < int'(NODES); i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < int'(N); i++) begin
      node[int'(LEAVES) - 1 + i] = OUT_W'($signed(terms[i*IN_W +: IN_W]));
    end
    for (int i = int'(LEAVES) - 2; i >= 0; i--) begin
      node[i] = node[2*i + 1] + node[2*i + 2];
    end
  end

  assign sum_c = node[0];

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multiply-accumulate with bias, channel accumulation
// and requantisation to DATA_SIZE bits.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input beat handshake (in_ready is combinational
//                        from out_ready)
//   in_first/in_last     burst delimiters; first loads bias, last emits
//   kernel_in, map_in    K packed signed elements each
//   bias                 signed bias, used on first beats
//   shift                requantisation shift, used on last beats
//   out_valid/out_ready  result handshake
//   mac_out              signed requantised result
// Build option: define MAC_RELU_EN to clamp negative results to zero.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int unsigned DATA_SIZE     = DEF_DATA_SIZE,
  parameter int unsigned KERNEL_WIDTH  = DEF_KERNEL_WIDTH,
  parameter int unsigned KERNEL_LENGTH = DEF_KERNEL_LENGTH,
  parameter int unsigned ACC_SIZE      = DEF_ACC_SIZE,
  parameter int unsigned SHIFT_W       = DEF_SHIFT_W
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic                                           in_first,
  input  logic                                           in_last,
  input  logic [DATA_SIZE*KERNEL_WIDTH*KERNEL_LENGTH-1:0] kernel_in,
  input  logic [DATA_SIZE*KERNEL_WIDTH*KERNEL_LENGTH-1:0] map_in,
  input  logic signed [ACC_SIZE-1:0]                     bias,
  input  logic [SHIFT_W-1:0]                             shift,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic signed [DATA_SIZE-1:0]                    mac_out
);

  localparam int unsigned KN = KERNEL_WIDTH * KERNEL_LENGTH;
  localparam int unsigned PW = 2 * DATA_SIZE;
  localparam int unsigned TW = PW + clog2(KN);

  logic en_c;

  logic [KN*PW-1:0]        prod_c;
  logic signed [TW-1:0]    tree_sum_c;
  logic signed [ACC_SIZE-1:0] base_c;
  logic signed [ACC_SIZE-1:0] total_c;
  logic signed [DATA_SIZE-1:0] rq_c;

  // Stage 1: products and sideband.
  logic                       s1_valid;
  logic                       s1_first;
  logic                       s1_last;
  logic signed [ACC_SIZE-1:0] s1_bias;
  logic [SHIFT_W-1:0]         s1_shift;
  logic [KN*PW-1:0]           s1_prod;

  // Stage 2: reduced sum and sideband.
  logic                       s2_valid;
  logic                       s2_first;
  logic                       s2_last;
  logic signed [ACC_SIZE-1:0] s2_bias;
  logic [SHIFT_W-1:0]         s2_shift;
  logic signed [ACC_SIZE-1:0] s2_sum;

  logic signed [ACC_SIZE-1:0] acc;

  // Whole pipe advances together; only a held, unaccepted result stalls it.
  assign en_c     = !out_valid || out_ready;
  assign in_ready = en_c;

  // Elementwise signed products at full 2*DATA_SIZE width.
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < int'(KN); i++) begin
      prod_c[i*PW +: PW] = PW'($signed(kernel_in[i*DATA_SIZE +: DATA_SIZE]))
                         * PW'($signed(map_in[i*DATA_SIZE +: DATA_SIZE]));
    end
  end

  mac_adder_tree #(
    .N     (KN),
    .IN_W  (PW),
    .OUT_W (TW)
  ) u_tree (
    .terms (s1_prod),
    .sum_c (tree_sum_c)
  );

  // Accumulate (wrapping) and requantise the running total.
  always_comb begin
    base_c  = s2_first ? s2_bias : acc;
    total_c = base_c + s2_sum;
    rq_c    = DATA_SIZE'(round_shift_sat(64'(total_c), ACC_SIZE,
                                         32'(s2_shift), DATA_SIZE));
`ifdef MAC_RELU_EN
    if (rq_c[DATA_SIZE-1]) begin
      rq_c = '0;
    end
`endif
  end

  // Pipeline registers; everything holds while en_c is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_bias   <= '0;
      s1_shift  <= '0;
      s1_prod   <= '0;
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_bias   <= '0;
      s2_shift  <= '0;
      s2_sum    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      mac_out   <= '0;
    end else if (en_c) begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_bias  <= bias;
      s1_shift <= shift;
      s1_prod  <= prod_c;

      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_bias  <= s1_bias;
      s2_shift <= s1_shift;
      s2_sum   <= ACC_SIZE'(tree_sum_c);

      if (s2_valid) begin
        acc <= total_c;
      end
      // With en_c high any held result is being accepted this cycle.
      if (s2_valid && s2_last) begin
        out_valid <= 1'b1;
        mac_out   <= rq_c;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
module tb_mac_pipe;
  import mac_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned KN = 9;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_first;
  logic                 in_last;
  logic [KN*DW-1:0]     kernel_in;
  logic [KN*DW-1:0]     map_in;
  logic [AW-1:0]        bias;
  logic [SW-1:0]        shift;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] mac_out;

  always #5 clk = ~clk;

  mac_pipe #(
    .DATA_SIZE     (DW),
    .KERNEL_WIDTH  (3),
    .KERNEL_LENGTH (3),
    .ACC_SIZE      (AW),
    .SHIFT_W       (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .kernel_in (kernel_in),
    .map_in    (map_in),
    .bias      (bias),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mac_out   (mac_out)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_results = 0;
  logic signed [DW-1:0] exp_q [$];
  logic signed [AW-1:0] m_acc = '0;
  bit                   hold_pend = 1'b0;
  logic signed [DW-1:0] held = '0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [KN*DW-1:0] fill(input logic [DW-1:0] v);
    logic [KN*DW-1:0] r;
    for (int i = 0; i < int'(KN); i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [KN*DW-1:0] rnd_vec();
    logic [KN*DW-1:0] r;
    for (int i = 0; i < int'(KN); i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Reference: dot product, wrapping accumulate, requantise on last beat.
  function automatic void model_beat(input logic f, input logic l,
                                     input logic [KN*DW-1:0] k, input logic [KN*DW-1:0] m,
                                     input logic [AW-1:0] b, input logic [SW-1:0] s);
    longint sum = 0;
    logic signed [DW-1:0] r;
    for (int i = 0; i < int'(KN); i++) begin
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] c;
      a = k[i*DW +: DW];
      c = m[i*DW +: DW];
      sum += longint'(a) * longint'(c);
    end
    m_acc = (f ? $signed(b) : m_acc) + AW'(sum);
    if (l) begin
      r = DW'(round_shift_sat(longint'(m_acc), AW, 32'(s), DW));
`ifdef MAC_RELU_EN
      if (r < 0) r = '0;
`endif
      exp_q.push_back(r);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send_beat(input logic f, input logic l,
                           input logic [KN*DW-1:0] k, input logic [KN*DW-1:0] m,
                           input logic [AW-1:0] b, input logic [SW-1:0] s);
    bit ok = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_first = f; in_last = l;
    kernel_in = k; map_in = m; bias = b; shift = s;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (ok) model_beat(f, l, k, m, b, s);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic wait_result(input string name, input longint exp);
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid && out_ready) begin
        got = 1'b1;
        check(name, longint'(mac_out), exp);
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no result after %0d cycles, expected %0d", name, n, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold stability.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", longint'(out_valid), 1);
          check("hold_data", longint'(mac_out), longint'(held));
        end
        if (out_valid && out_ready) begin
          n_results++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: got %0d expected no result", mac_out);
          end else begin
            check("scoreboard", longint'(mac_out), longint'(exp_q.pop_front()));
          end
        end
        hold_pend = out_valid && !out_ready;
        held      = mac_out;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KN*DW-1:0] kv;
    logic [KN*DW-1:0] mv;
    int r0;
    bit done;

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    kernel_in = '0; map_in = '0; bias = '0; shift = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_mac_out", longint'(mac_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0;

    // Single beat, latency k+2.
    send_beat(1'b1, 1'b1, fill(8'd20), fill(8'd80), 32'd128, 5'd7);
    in_valid = 1'b0;
    @(negedge clk); check("lat_s1", longint'(out_valid), 0);
    @(negedge clk); check("lat_s2", longint'(out_valid), 0);
    @(negedge clk); check("lat_out", longint'(out_valid), 1);
    check("single_114", longint'(mac_out), 114);
    @(posedge clk); #1;

    send_beat(1'b1, 1'b1, fill(8'd20), fill(8'd80), 32'd128, 5'd0);
    in_valid = 1'b0;
    wait_result("sat_pos", 127);

    send_beat(1'b1, 1'b1, fill(8'hEC), fill(8'd80), 32'd0, 5'd7);
    in_valid = 1'b0;
`ifdef MAC_RELU_EN
    wait_result("neg_relu", 0);
`else
    wait_result("neg_112", -112);
`endif

    // Three-beat burst yields exactly one result.
    drain();
    r0 = n_results;
    send_beat(1'b1, 1'b0, fill(8'd1), fill(8'd1), 32'd10, 5'd0);
    send_beat(1'b0, 1'b0, fill(8'd1), fill(8'd1), 32'd99, 5'd9);
    send_beat(1'b0, 1'b1, fill(8'd1), fill(8'd1), 32'd99, 5'd0);
    in_valid = 1'b0;
    wait_result("burst_37", 37);
    drain();
    check("burst_count", longint'(n_results - r0), 1);

    // First beat mid-burst discards the partial sum.
    send_beat(1'b1, 1'b0, fill(8'd1), fill(8'd1), 32'd100, 5'd0);
    send_beat(1'b1, 1'b1, fill(8'd1), fill(8'd1), 32'd0, 5'd0);
    in_valid = 1'b0;
    wait_result("restart_9", 9);

    // Back-to-back results with a 5-cycle downstream stall.
    drain();
    r0 = n_results;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send_beat(1'b1, 1'b1, rnd_vec(), rnd_vec(), AW'($urandom), SW'($urandom));
        in_valid = 1'b0;
      end
      begin
        int n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (!out_valid) begin
          n_cmp++; n_bad++;
          $display("FAIL stall_start: out_valid %0d expected 1", out_valid);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", longint'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", longint'(n_results - r0), 12);

    // Reset mid-burst loses the partial sum; next non-first beat has no bias.
    send_beat(1'b1, 1'b0, fill(8'd3), fill(8'd3), 32'd50, 5'd0);
    send_beat(1'b0, 1'b0, fill(8'd3), fill(8'd3), 32'd0, 5'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_in_ready", longint'(in_ready), 1);
    check("rstmid_out_valid", longint'(out_valid), 0);
    check("rstmid_mac_out", longint'(mac_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0;
    kv = '0; kv[DW-1:0] = 8'd1;
    mv = '0; mv[DW-1:0] = 8'd9;
    send_beat(1'b0, 1'b1, kv, mv, 32'd77, 5'd0);
    in_valid = 1'b0;
    wait_result("post_rst_9", 9);

    // Randomised traffic with random backpressure and gaps.
    drain();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_beat(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                    rnd_vec(), rnd_vec(), AW'($urandom), SW'($urandom));
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
